// File: rtl/gpio_in_debounce.sv
// Per-channel input conditioning: synchroniser, debounce counter, edge pulses and sticky press flags.
// Optional long-press detector is built when GPIO_DEBOUNCE_LONG_PRESS_EN is defined.
module gpio_in_debounce #(
  parameter int   WIDTH           = 8,
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 65536,
  parameter logic RESET_LEVEL     = 1'b0,
  parameter int   LONG_CYCLES     = 2**24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             event_o,
  output logic [WIDTH-1:0] latched_o,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] clear_mask_i,
  output logic [WIDTH-1:0] long_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [CNT_W-1:0] cnt    [WIDTH];
  logic [CNT_W-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0] level_d;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= {WIDTH{RESET_LEVEL}};
    end else begin
      sync_q[0] <= pin_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Any cycle where the synchronised pin agrees with the accepted level restarts the count.
  always_comb begin
    level_d = level_o;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s[i] != level_o[i]) begin
        if (cnt[i] == CNT_MAX) begin
          level_d[i] = s[i];
          rise_d[i]  = s[i];
          fall_d[i]  = ~s[i];
        end else begin
          cnt_d[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_o   <= {WIDTH{RESET_LEVEL}};
      rise_o    <= '0;
      fall_o    <= '0;
      latched_o <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      level_o   <= level_d;
      rise_o    <= rise_d;
      fall_o    <= fall_d;
      latched_o <= rise_o | (latched_o & ~({WIDTH{clear_i}} & clear_mask_i));
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_d[i];
    end
  end

  assign event_o = |(rise_o | fall_o);

`ifdef GPIO_DEBOUNCE_LONG_PRESS_EN
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYCLES - 2);

  logic [HOLD_W-1:0] hold [WIDTH];

  // Hold counter restarts on each accepted edge and saturates so the pulse cannot repeat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_o <= '0;
      for (int i = 0; i < WIDTH; i++) hold[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        long_o[i] <= 1'b0;
        if (rise_d[i] || fall_d[i]) begin
          hold[i] <= '0;
        end else if (level_o[i] && (hold[i] != HOLD_MAX)) begin
          hold[i]   <= hold[i] + HOLD_W'(1);
          long_o[i] <= (hold[i] == HOLD_PRE);
        end
      end
    end
  end
`else
  logic unused_long_cycles;
  assign unused_long_cycles = ^LONG_CYCLES;
  assign long_o = '0;
`endif

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Scoreboard bench for gpio_in_debounce: a queue-based reference model predicts every cycle's outputs.
// Build with GPIO_DEBOUNCE_LONG_PRESS_EN defined to exercise the long-press pulse.
module tb_gpio_in_debounce;
  localparam int   W  = 8;
  localparam int   SS = 2;
  localparam int   D  = 4;
  localparam int   L  = 16;
  localparam logic RL = 1'b0;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] pin;
  logic         clr;
  logic [W-1:0] mask;
  logic [W-1:0] level, rise, fall, latched, long_p;
  logic         ev;

  gpio_in_debounce #(
    .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(D), .RESET_LEVEL(RL), .LONG_CYCLES(L)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pin_i(pin), .level_o(level), .rise_o(rise), .fall_o(fall),
    .event_o(ev), .latched_o(latched), .clear_i(clr), .clear_mask_i(mask), .long_o(long_p)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] level, rise, fall, latched, long_p;
    logic         ev;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   passed = 0;
  bit   started = 0;

  // Reference model: a delay line of sampled pins plus per-channel run lengths of disagreement.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_level, m_rise, m_fall, m_latched, m_long;
  int           run[W];
  int           hold[W];

  task automatic modelReset();
    hist.delete();
    for (int k = 0; k < SS; k++) hist.push_back({W{RL}});
    m_level = {W{RL}}; m_rise = '0; m_fall = '0; m_latched = '0; m_long = '0;
    for (int i = 0; i < W; i++) begin run[i] = 0; hold[i] = 0; end
  endtask

  task automatic modelStep();
    exp_t e;
    logic [W-1:0] s, old_level;
    if (!rst_n) begin
      modelReset();
    end else begin
      s = hist.pop_front();
      hist.push_back(pin);
      old_level = m_level;
      m_latched = m_rise | (m_latched & ~(clr ? mask : '0));
      m_rise = '0; m_fall = '0; m_long = '0;
      for (int i = 0; i < W; i++) begin
        if (s[i] == m_level[i]) run[i] = 0;
        else begin
          run[i]++;
          if (run[i] == D) begin
            run[i] = 0;
            m_level[i] = s[i];
            if (s[i]) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
          end
        end
`ifdef GPIO_DEBOUNCE_LONG_PRESS_EN
        if (m_rise[i] || m_fall[i]) hold[i] = 0;
        else if (old_level[i] && hold[i] < L) begin
          hold[i]++;
          if (hold[i] == L - 1) m_long[i] = 1'b1;
        end
`endif
      end
    end
    e.level = m_level; e.rise = m_rise; e.fall = m_fall; e.latched = m_latched;
    e.long_p = m_long; e.ev = |(m_rise | m_fall);
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Inputs change just after the falling edge; the next rising edge consumes them.
  task automatic applyStimulus(input logic r, input logic [W-1:0] p, input logic c, input logic [W-1:0] m);
    rst_n = r; pin = p; clr = c; mask = m;
    @(posedge clk);
    started = 1;
    modelStep();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (started) begin
      if (sb.size() == 0) checkOutput("sb_empty", 8'h01, 8'h00);
      else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("level", level, e.level);
        checkOutput("rise", rise, e.rise);
        checkOutput("fall", fall, e.fall);
        checkOutput("event", {7'b0, ev}, {7'b0, e.ev});
        checkOutput("latched", latched, e.latched);
        checkOutput("long", long_p, e.long_p);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [W-1:0] p;
    int rise_at, long_at, long_cnt;
    modelReset();

    // Test 1: reset with all pins high, then release low.
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 8'hFF, 1'b0, 8'h00);
    checkOutput("t1_level", level, 8'h00);
    checkOutput("t1_latched", latched, 8'h00);
    checkOutput("t1_pulses", rise | fall | long_p, 8'h00);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 8'h00, 1'b0, 8'h00);
      checkOutput("t1_event", {7'b0, ev}, 8'h00);
    end

    // Test 2: single press on bit 0.
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(1'b1, 8'h01, 1'b0, 8'h00);
      checkOutput("t2_rise", rise, (k == 6) ? 8'h01 : 8'h00);
      if (k == 5) checkOutput("t2_level_early", level, 8'h00);
      if (k == 6) checkOutput("t2_event", {7'b0, ev}, 8'h01);
    end
    checkOutput("t2_latched", latched, 8'h01);

    // Test 3: bounce on bit 3; final steady high starts at step 5.
    for (int k = 1; k <= 12; k++) begin
      p = 8'h01;
      if (k != 4) p[3] = 1'b1;
      applyStimulus(1'b1, p, 1'b0, 8'h00);
      checkOutput("t3_rise", rise, (k == 10) ? 8'h08 : 8'h00);
    end

    // Test 4: set-wins-over-clear, then a masked clear.
    applyStimulus(1'b1, 8'h09, 1'b1, 8'hFF);
    checkOutput("t4_clear_all", latched, 8'h00);
    for (int k = 0; k < 7; k++) applyStimulus(1'b1, 8'h0C, 1'b0, 8'h00);
    checkOutput("t4_bit2", latched, 8'h04);
    for (int k = 1; k <= 6; k++) applyStimulus(1'b1, 8'h0D, 1'b0, 8'h00);
    checkOutput("t4_rise0", rise, 8'h01);
    applyStimulus(1'b1, 8'h0D, 1'b1, 8'h01);
    checkOutput("t4_set_wins", latched, 8'h05);
    applyStimulus(1'b1, 8'h0D, 1'b1, 8'h05);
    checkOutput("t4_cleared", latched, 8'h00);

    // Test 5: reset while bit 1 is part-way through its count.
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 8'h0F, 1'b0, 8'h00);
    for (int k = 0; k < 2; k++) applyStimulus(1'b0, 8'h02, 1'b0, 8'h00);
    checkOutput("t5_level_rst", level, 8'h00);
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b1, 8'h02, 1'b0, 8'h00);
      checkOutput("t5_rise", rise, (k == 6) ? 8'h02 : 8'h00);
      checkOutput("t5_fall", fall, 8'h00);
    end

    // Test 6: hold bit 7 for 40 cycles after its rise.
    rise_at = -1; long_at = -1; long_cnt = 0;
    for (int k = 1; k <= 46; k++) begin
      applyStimulus(1'b1, 8'h82, 1'b0, 8'h00);
      if (rise[7]) rise_at = k;
      if (long_p != 8'h00) begin long_cnt++; long_at = k; end
    end
    checkOutput("t6_rise_at", 8'(rise_at), 8'd6);
`ifdef GPIO_DEBOUNCE_LONG_PRESS_EN
    checkOutput("t6_long_cnt", 8'(long_cnt), 8'd1);
    checkOutput("t6_long_delay", 8'(long_at - rise_at), 8'd15);
`else
    checkOutput("t6_long_cnt", 8'(long_cnt), 8'd0);
`endif

    // Random phase: slow level changes, short glitches, random clears, rare resets.
    p = 8'h02;
    for (int c = 0; c < 500; c++) begin
      int r;
      logic [W-1:0] drive;
      r = $urandom_range(0, 99);
      if (r < 15) p ^= 8'(1 << $urandom_range(0, 7));
      drive = p;
      if (r >= 15 && r < 22) drive = p ^ 8'(1 << $urandom_range(0, 7));
      applyStimulus(($urandom_range(0, 149) != 0), drive, ($urandom_range(0, 3) == 0), 8'($urandom));
    end
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, p, 1'b0, 8'h00);

    checkOutput("sb_drained", 8'(sb.size()), 8'h00);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
